deck_dealer: RTL and testbench

//  Responder end of the controller's deck handshake: holds a 52-card deck, shuffles it from a 6-bit

---
 rtl/deck_pkg.sv | 25 ++
 rtl/deck_dealer_if.sv | 25 ++
 rtl/deck_lfsr.sv | 36 +++
 rtl/deck_dealer.sv | 144 ++++++++++++++
 tb/tb_deck_dealer.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/deck_pkg.sv
// Shared constants, types and FSM state encoding for the deck dealer.

package deck_pkg;

    localparam int unsigned RANKS     = 13;
    localparam int unsigned SUITS     = 4;
    localparam int unsigned DECK_SIZE = RANKS * SUITS;

    typedef logic [3:0] card_t;
    typedef logic [5:0] seed_t;

    localparam card_t CARD_NONE    = 4'd0;
    localparam seed_t DEFAULT_SEED = 6'h2A;
    // x^6 + x^5 + 1
    localparam seed_t LFSR_TAPS    = 6'b110000;

    typedef enum logic [2:0] {
        StIdle,
        StShufLoad,
        StShufDraw,
        StDealFetch,
        StDealDone
    } dealer_state_e;

endpackage

// File: rtl/deck_dealer_if.sv
// Controller <-> dealer handshake: shuffle/deal requests in, readies and card out.

interface deck_dealer_if;
    import deck_pkg::*;

    logic  shuffle_start;
    seed_t seed;
    logic  card_start;
    logic  shuffle_ready;
    logic  card_ready;
    card_t card;
    logic  card_overflow;
    logic  shuffling;

    modport master (
        output shuffle_start, seed, card_start,
        input  shuffle_ready, card_ready, card, card_overflow, shuffling
    );

    modport slave (
        input  shuffle_start, seed, card_start,
        output shuffle_ready, card_ready, card, card_overflow, shuffling
    );

endinterface

// File: rtl/deck_lfsr.sv
// 6-bit Fibonacci LFSR with load/step enables; a zero seed is replaced to avoid lock-up.

module deck_lfsr
    import deck_pkg::*;
#(
    parameter seed_t DefaultSeed = DEFAULT_SEED
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  load_i,
    input  logic  step_i,
    input  seed_t seed_i,
    output seed_t next_o
);

    seed_t lfsr_q, lfsr_d;

    always_comb begin
        next_o = {lfsr_q[4:0], ^(lfsr_q & LFSR_TAPS)};
        lfsr_d = lfsr_q;
        if (load_i) begin
            lfsr_d = (seed_i == '0) ? DefaultSeed : seed_i;
        end else if (step_i) begin
            lfsr_d = next_o;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            lfsr_q <= DefaultSeed;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

endmodule

// File: rtl/deck_dealer.sv
// 52-card deck holder: seed-deterministic Fisher-Yates shuffle and one-card-per-request dealing.

module deck_dealer
    import deck_pkg::*;
#(
    parameter int unsigned Ranks       = RANKS,
    parameter int unsigned Suits       = SUITS,
    parameter seed_t       DefaultSeed = DEFAULT_SEED
) (
    input logic          clk,
    input logic          rst,
    deck_dealer_if.slave dk
);

    localparam int unsigned DeckSize = Ranks * Suits;
    localparam logic [5:0]  LastIdx  = 6'(DeckSize - 1);

    dealer_state_e state_q, state_d;
    card_t         deck_q [DeckSize];
    card_t         deck_d [DeckSize];
    logic [5:0]    ptr_q, ptr_d;
    logic [5:0]    idx_q, idx_d;
    card_t         card_q, card_d;
    logic          ovf_q, ovf_d;
    logic          shuf_q, shuf_d;
    logic          ready_q, ready_d;

    logic  lfsr_load, lfsr_step;
    seed_t lfsr_next;
    logic [5:0] draw_r;

    deck_lfsr #(
        .DefaultSeed (DefaultSeed)
    ) u_lfsr (
        .clk    (clk),
        .rst    (rst),
        .load_i (lfsr_load),
        .step_i (lfsr_step),
        .seed_i (dk.seed),
        .next_o (lfsr_next)
    );

    // Candidate swap index, 0..62; values above idx are rejected and redrawn.
    assign draw_r = lfsr_next - 6'd1;

    always_comb begin
        state_d   = state_q;
        deck_d    = deck_q;
        ptr_d     = ptr_q;
        idx_d     = idx_q;
        card_d    = card_q;
        ovf_d     = ovf_q;
        shuf_d    = shuf_q;
        ready_d   = ready_q;
        lfsr_load = 1'b0;
        lfsr_step = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (dk.shuffle_start) begin
                    state_d   = StShufLoad;
                    ready_d   = 1'b0;
                    shuf_d    = 1'b1;
                    lfsr_load = 1'b1;
                end else if (dk.card_start) begin
                    state_d = StDealFetch;
                    ready_d = 1'b0;
                end
            end
            StShufLoad: begin
                for (int p = 0; p < DeckSize; p++) begin
                    deck_d[p] = card_t'((p % Ranks) + 1);
                end
                idx_d   = LastIdx;
                state_d = StShufDraw;
            end
            StShufDraw: begin
                lfsr_step = 1'b1;
                if (draw_r <= idx_q) begin
                    deck_d[idx_q]  = deck_q[draw_r];
                    deck_d[draw_r] = deck_q[idx_q];
                    idx_d          = idx_q - 6'd1;
                    if (idx_q == 6'd1) begin
                        state_d = StIdle;
                        ptr_d   = '0;
                        ovf_d   = 1'b0;
                        shuf_d  = 1'b0;
                        ready_d = 1'b1;
                    end
                end
            end
            StDealFetch: begin
                state_d = StDealDone;
            end
            StDealDone: begin
                state_d = StIdle;
                ready_d = 1'b1;
                if (ptr_q < 6'(DeckSize)) begin
                    card_d = deck_q[ptr_q];
                    ptr_d  = ptr_q + 6'd1;
                end else begin
                    card_d = CARD_NONE;
                    ovf_d  = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
                ready_d = 1'b1;
                shuf_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= StIdle;
            for (int p = 0; p < DeckSize; p++) begin
                deck_q[p] <= card_t'((p % Ranks) + 1);
            end
            ptr_q   <= '0;
            idx_q   <= '0;
            card_q  <= CARD_NONE;
            ovf_q   <= 1'b0;
            shuf_q  <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            deck_q  <= deck_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            card_q  <= card_d;
            ovf_q   <= ovf_d;
            shuf_q  <= shuf_d;
            ready_q <= ready_d;
        end
    end

    assign dk.shuffle_ready = ready_q;
    assign dk.card_ready    = ready_q;
    assign dk.card          = card_q;
    assign dk.card_overflow = ovf_q;
    assign dk.shuffling     = shuf_q;

endmodule

// File: tb/tb_deck_dealer.sv
// Directed bench for deck_dealer: ordered deals, seeded shuffles vs. a reference shuffle, overflow,
// start collisions and mid-operation reset.

module tb_deck_dealer;
    import deck_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;

    deck_dealer_if dif ();

    deck_dealer dut (
        .clk (clk),
        .rst (rst),
        .dk  (dif)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;
    int exp_deck [52];
    int rank_cnt [14];
    int c, low, prev_card;

    task automatic check(input string tag, input int got, input int exp);
        n_total++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference Fisher-Yates driven by the x^6+x^5+1 sequence, rejection above i.
    task automatic model_shuffle(input logic [5:0] s);
        logic [5:0] l;
        int i, r, t;
        for (int p = 0; p < 52; p++) exp_deck[p] = (p % 13) + 1;
        l = (s == 6'd0) ? 6'h2A : s;
        i = 51;
        while (i >= 1) begin
            l = {l[4:0], l[5] ^ l[4]};
            r = int'(l) - 1;
            if (r <= i) begin
                t           = exp_deck[i];
                exp_deck[i] = exp_deck[r];
                exp_deck[r] = t;
                i--;
            end
        end
    endtask

    task automatic wait_ready(input int bound, input string tag);
        int n = 0;
        while (!dif.card_ready && n < bound) begin
            tick();
            n++;
        end
        check(tag, int'(dif.card_ready), 1);
    endtask

    task automatic deal(output int card, output int low_cycles);
        dif.card_start = 1'b1;
        tick();
        dif.card_start = 1'b0;
        low_cycles = 0;
        while (!dif.card_ready && low_cycles < 8) begin
            low_cycles++;
            tick();
        end
        card = int'(dif.card);
    endtask

    task automatic shuffle(input logic [5:0] s);
        dif.seed          = s;
        dif.shuffle_start = 1'b1;
        tick();
        dif.shuffle_start = 1'b0;
        check("shuf_busy", int'(dif.shuffling), 1);
        check("shuf_rdy_low", int'(dif.shuffle_ready), 0);
        check("card_rdy_low", int'(dif.card_ready), 0);
        wait_ready(51 * 63 + 4, "shuf_done");
        check("shuf_end", int'(dif.shuffling), 0);
        check("shuf_ovf_clr", int'(dif.card_overflow), 0);
    endtask

    task automatic deal_deck(input string tag);
        int cc, ll;
        for (int r = 0; r < 14; r++) rank_cnt[r] = 0;
        for (int k = 0; k < 52; k++) begin
            deal(cc, ll);
            check(tag, cc, exp_deck[k]);
            if (cc >= 0 && cc < 14) rank_cnt[cc]++;
        end
        for (int r = 1; r < 14; r++) check("rank_count", rank_cnt[r], 4);
    endtask

    initial begin
        dif.shuffle_start = 1'b0;
        dif.card_start    = 1'b0;
        dif.seed          = 6'd0;
        tick();
        tick();
        rst = 1'b1;

        check("rst_shuf_rdy", int'(dif.shuffle_ready), 1);
        check("rst_card_rdy", int'(dif.card_ready), 1);
        check("rst_card", int'(dif.card), 0);
        check("rst_ovf", int'(dif.card_overflow), 0);
        check("rst_shuffling", int'(dif.shuffling), 0);

        // 1: ordered deck without a shuffle
        for (int k = 0; k < 14; k++) begin
            deal(c, low);
            check("ordered_card", c, (k % 13) + 1);
            check("deal_low_cycles", low, 2);
            check("ordered_ovf", int'(dif.card_overflow), 0);
        end

        // 2: seed 10, then the same after a reset
        model_shuffle(6'd10);
        shuffle(6'd10);
        deal_deck("seed10_card");
        rst = 1'b0;
        tick();
        rst = 1'b1;
        shuffle(6'd10);
        deal_deck("seed10_repeat");

        // 3: zero seed behaves as the default seed
        model_shuffle(6'h2A);
        shuffle(6'd0);
        deal_deck("seed0_card");
        shuffle(6'h2A);
        deal_deck("seed2a_card");

        // 4: exhaustion
        deal(c, low);
        check("deal53_card", c, 0);
        check("deal53_ovf", int'(dif.card_overflow), 1);
        deal(c, low);
        check("deal54_card", c, 0);
        check("deal54_ovf", int'(dif.card_overflow), 1);
        model_shuffle(6'd5);
        shuffle(6'd5);
        deal(c, low);
        check("after_ovf_card", c, exp_deck[0]);
        check("after_ovf_nonzero", int'(c != 0), 1);
        prev_card = exp_deck[0];

        // 5: simultaneous starts, then card_start noise while busy
        model_shuffle(6'd7);
        dif.seed          = 6'd7;
        dif.shuffle_start = 1'b1;
        dif.card_start    = 1'b1;
        tick();
        dif.shuffle_start = 1'b0;
        dif.card_start    = 1'b0;
        check("both_shuffling", int'(dif.shuffling), 1);
        tick();
        dif.card_start = 1'b1;
        tick();
        dif.card_start = 1'b0;
        tick();
        dif.card_start = 1'b1;
        tick();
        dif.card_start = 1'b0;
        wait_ready(51 * 63 + 4, "both_done");
        check("both_card_kept", int'(dif.card), prev_card);
        check("both_ovf", int'(dif.card_overflow), 0);
        deal(c, low);
        check("both_first_deal", c, exp_deck[0]);
        deal(c, low);
        check("both_second_deal", c, exp_deck[1]);

        // 6: reset during SHUF_DRAW and during DEAL_FETCH
        dif.seed          = 6'd9;
        dif.shuffle_start = 1'b1;
        tick();
        dif.shuffle_start = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check("rstshuf_rdy", int'(dif.shuffle_ready), 1);
        check("rstshuf_card_rdy", int'(dif.card_ready), 1);
        check("rstshuf_card", int'(dif.card), 0);
        check("rstshuf_shuffling", int'(dif.shuffling), 0);
        deal(c, low);
        check("rstshuf_deal", c, 1);
        dif.card_start = 1'b1;
        tick();
        dif.card_start = 1'b0;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check("rstdeal_rdy", int'(dif.card_ready), 1);
        check("rstdeal_card", int'(dif.card), 0);
        check("rstdeal_shuffling", int'(dif.shuffling), 0);
        deal(c, low);
        check("rstdeal_deal", c, 1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
